seq_detect_1101: RTL
====================

SEQ_DETECT_1101 -- requirements
Module: seq_detect_1101

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of match counter (2..16).
REQ-002 SHALL have port: clk_i  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: bit_i  input  1  serial data bit from upstream pattern generator.
REQ-005 SHALL have port: bit_vld_i  input  1  bit_i is valid this cycle; bit is consumed on this edge.
REQ-006 SHALL have port: clr_i  input  1  synchronous clear of FSM and counter.
REQ-007 SHALL have port: match_o  output  1  one-cycle pulse, pattern 1101 completed.
REQ-008 SHALL have port: match_cnt_o  output  CNT_W  saturating count of matches.
REQ-009 SHALL have port: state_o  output  3  current FSM state encoding, debug only.

Function
REQ-010 SHALL detect serial pattern 1,1,0,1 (first-received bit first) on valid bits only, with overlap.
REQ-011 SHALL implement FSM states: IDLE=0, S1=1, S11=2, S110=3, S1101=4; codes 5-7 are unused.
REQ-012 SHALL use these transitions on a valid bit (bit 0 / bit 1): IDLE -> IDLE/S1; S1 -> IDLE/S11; S11 -> S110/S11; S110 -> IDLE/S1101; S1101 -> IDLE/S11.
REQ-013 SHALL hold state unchanged in any cycle where bit_vld_i=0.
REQ-014 SHALL force any unused state code to IDLE on the next edge, regardless of bit_vld_i.
REQ-015 SHALL register match_o and assert it in the cycle after the edge that consumes the completing bit: latency 1 cycle; asserted iff next state is S1101 and bit_vld_i=1.
REQ-016 SHALL keep match_o high for exactly one cycle per match, even if bit_vld_i is low on following cycles.
REQ-017 SHALL increment match_cnt_o on the same edge that sets match_o.
REQ-018 SHALL saturate match_cnt_o at 2^CNT_W-1; no wrap to 0.
REQ-019 SHALL act on clr_i=1 at the next edge: state -> IDLE, match_cnt_o -> 0, match_o -> 0.
REQ-020 SHALL give clr_i priority over bit_vld_i; a bit presented while clr_i=1 is discarded.
REQ-021 SHALL drive state_o directly from the state register, zero-extended to 3 bits.

Reset
REQ-022 SHALL, while rst_n_i=0, immediately force state=IDLE, match_o=0, match_cnt_o=0, and state_o=0.
REQ-023 SHALL resume on the first rising edge after rst_n_i deasserts; a partial pattern in progress at reset is lost.

Verification
REQ-024 SHALL cover: bits 1,1,0,1 with bit_vld_i=1 for 4 consecutive cycles -> match_o=1 for one cycle, 1 cycle after the 4th bit; match_cnt_o=1.
REQ-025 SHALL cover: overlapping stream 1,1,0,1,1,0,1 -> 2 match pulses, 3 cycles apart; match_cnt_o=2.
REQ-026 SHALL cover: 1,1 then bit_vld_i=0 for 5 cycles, then 0,1 -> state_o=2 held through the gap, 1 match, no spurious pulses.
REQ-027 SHALL cover: 300 matches with CNT_W=8 -> match_cnt_o stops at 255; match_o still pulses 300 times.
REQ-028 SHALL cover: clr_i=1 with bit_vld_i=1 and bit_i=1 while in S110 -> state_o=0, match_cnt_o=0, no match_o.
REQ-029 SHALL cover: rst_n_i pulsed low mid-pattern (in S11) between edges -> outputs 0 immediately; next 0,1 produces no match.

Source files
------------

// File: rtl/seq_detect_1101.sv
// Serial 1101 pattern detector with overlap, registered match pulse and
// a saturating match counter. Only bits qualified by bit_vld_i advance the FSM.
module seq_detect_1101 #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             bit_i,
   input  logic             bit_vld_i,
   input  logic             clr_i,
   output logic             match_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S1    = 3'd1,
      S11   = 3'd2,
      S110  = 3'd3,
      S1101 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state_q;
   state_t state_d;
   logic   match_d;

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: clear wins, unused codes recover to IDLE, otherwise advance on valid bits
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bit_vld_i) state_d = bit_i ? S1    : IDLE;
            S1:      if (bit_vld_i) state_d = bit_i ? S11   : IDLE;
            S11:     if (bit_vld_i) state_d = bit_i ? S11   : S110;
            S110:    if (bit_vld_i) state_d = bit_i ? S1101 : IDLE;
            S1101:   if (bit_vld_i) state_d = bit_i ? S11   : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: a match is a valid bit landing in S1101; state is exposed for debug
   always_comb begin
      match_d = bit_vld_i && !clr_i && (state_d == S1101);
      state_o = state_q;
   end

   // Registered pulse and saturating counter, both updated on the consuming edge
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         match_o     <= 1'b0;
         match_cnt_o <= '0;
      end else if (clr_i) begin
         match_o     <= 1'b0;
         match_cnt_o <= '0;
      end else begin
         match_o <= match_d;
         if (match_d && (match_cnt_o != CNT_MAX))
            match_cnt_o <= match_cnt_o + 1'b1;
      end
   end

endmodule
